// File: rtl/logging_arbiter_if.sv
// Channel-side and output-side handshake bundle for logging_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface logging_arbiter_if #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_WIDTH = $clog2(N_CH);

    logic [N_CH-1:0]            logb_valid;
    logic [N_CH-1:0]            logb_ready;
    logic [N_CH*DATA_WIDTH-1:0] logb_data;
    logic [N_CH-1:0]            loge_valid;
    logic [N_CH-1:0]            loge_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      out_data;
    logic [ID_WIDTH-1:0]        out_id;
    logic                       out_b;
    logic                       out_e;

    modport slave (
        input  logb_valid, logb_data, loge_valid, out_ready,
        output logb_ready, loge_ready, out_valid, out_data, out_id, out_b, out_e
    );

    modport master (
        output logb_valid, logb_data, loge_valid, out_ready,
        input  logb_ready, loge_ready, out_valid, out_data, out_id, out_b, out_e
    );
endinterface

// File: rtl/logging_arbiter.sv
// Round-robin merge of N_CH logb/loge channel pairs into one tagged record stream,
// buffered by a 2-entry FIFO so input readies never depend on out_ready.
module logging_arbiter #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    logging_arbiter_if.slave bus
);
    localparam int ID_WIDTH = $clog2(N_CH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic                  b;
        logic                  e;
    } rec_t;

    logic [N_CH-1:0]     w_req;
    logic [N_CH-1:0]     w_ready;
    logic                w_space;
    logic                w_found;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;
    logic [ID_WIDTH-1:0] w_win;
    rec_t                w_rec;

    logic [1:0]          r_cnt;
    logic                r_rd;
    logic                r_wr;
    logic [ID_WIDTH-1:0] r_ptr;
    rec_t                r_mem [2];

    always_comb begin
        w_req   = bus.logb_valid | bus.loge_valid;
        w_space = (r_cnt != 2'd2);
        w_found = 1'b0;
        w_win   = '0;
        // Two passes give the wrap-around scan: ptr..N_CH-1 first, then 0..ptr-1.
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!w_found && w_req[i] && (ID_WIDTH'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_win   = ID_WIDTH'(i);
            end
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!w_found && w_req[i]) begin
                w_found = 1'b1;
                w_win   = ID_WIDTH'(i);
            end
        end

        w_grant = rstn && w_space && w_found;
        w_ready = '0;
        w_rec   = '0;
        w_rec.id = w_win;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_win == ID_WIDTH'(i)) begin
                w_ready[i] = w_grant;
                w_rec.b    = bus.logb_valid[i];
                w_rec.e    = bus.loge_valid[i];
                w_rec.data = bus.logb_valid[i] ? bus.logb_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
        end

        w_push = w_grant;
        w_pop  = (r_cnt != 2'd0) && bus.out_ready;
    end

    assign bus.logb_ready = w_ready;
    assign bus.loge_ready = w_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_ptr    <= '0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_rec;
                r_wr        <= ~r_wr;
                r_ptr       <= (w_win == ID_WIDTH'(N_CH - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Head entry is register-driven, so payload holds while out_ready is low.
    assign bus.out_valid = (r_cnt != 2'd0);
    assign bus.out_data  = r_mem[r_rd].data;
    assign bus.out_id    = r_mem[r_rd].id;
    assign bus.out_b     = r_mem[r_rd].b;
    assign bus.out_e     = r_mem[r_rd].e;
endmodule

// File: doc/logging_arbiter.md
# logging_arbiter

Round-robin scheduler that shares one logging output stream among `N_CH` channel loggers. Each channel presents a begin-record stream (logb, with data) and an end-marker stream (loge, no data) whose ready signals must always be equal. The block grants one channel per cycle, drives that channel's logb/loge readies together, and emits a single tagged record into a 2-entry output buffer feeding the downstream log writer.

## Interface
Parameters:
- `N_CH`, 4: number of channels, 2..16.
- `DATA_WIDTH`, 32: logb payload width.
- `ID_WIDTH`, `$clog2(N_CH)`: channel-id width (derived, not overridden).

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; one clock, reset is asynchronous and active-low.
- `logb_valid`  in  N_CH  per-channel begin-record valid.
- `logb_ready`  out  N_CH  per-channel begin-record ready.
- `logb_data`  in  N_CH*DATA_WIDTH  channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `loge_valid`  in  N_CH  per-channel end-marker valid.
- `loge_ready`  out  N_CH  per-channel end-marker ready; always bit-identical to `logb_ready`.
- `out_valid`  out  1  record valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_WIDTH  logb payload; 0 when `out_b`=0.
- `out_id`  out  ID_WIDTH  source channel.
- `out_b`  out  1  record carries a logb beat.
- `out_e`  out  1  record carries a loge beat.

## Operation
- Request: `req[i] = logb_valid[i] | loge_valid[i]`.
- Output buffer: 2-entry FIFO, registered occupancy `cnt` (0..2). `space = (cnt != 2)`, from registers only; no combinational path from `out_ready` to any input ready.
- Pointer `ptr` (ID_WIDTH bits, reset 0). Winner = first i with `req[i]` scanning ptr, ptr+1, …, N_CH-1, 0, …, ptr-1.
- Grant valid when `space` and any `req`. Then `logb_ready[w] = loge_ready[w] = 1`; all other bits 0. No grant -> all readies 0.
- On grant, push record {data = logb_valid[w] ? logb_data[w] : 0, id = w, b = logb_valid[w], e = loge_valid[w]}. Both beats of channel w transfer in the same cycle if both valid; a lone loge or lone logb is also a legal record (`out_b|out_e` always 1).
- Pointer update on grant: `ptr <= (w == N_CH-1) ? 0 : w+1`. No grant -> ptr holds.
- FIFO: push and pop in the same cycle allowed at any `cnt` where each is legal (pop needs cnt>0, push needs cnt<2); cnt changes by push-pop. Output driven from head entry.
- Fairness: a channel with `req` held high is granted within N_CH grant cycles.
- Reset (async assert, any time incl. mid-transfer): cnt=0, ptr=0, FIFO contents discarded; `out_valid`=0, all `logb_ready`/`loge_ready`=0 while `rstn`=0. Outputs `out_data`,`out_id`,`out_b`,`out_e` reset to 0.
- Input protocol required of channels: valid held with stable data until ready; the block never deasserts a ready to a granted channel within that cycle.

## Timing
- Latency: record granted in cycle t appears on `out_valid` at t+1 (cnt was 0) or behind queued entries.
- Throughput: 1 record/cycle sustained with `out_ready`=1.
- Backpressure: `out_ready`=0 for two cycles after fill -> cnt=2 -> no grants next cycle; one pop restores `space` the cycle after it.
- Output holds `out_valid` and all payload stable while `out_ready`=0.
- Ready outputs are combinational from `*_valid`, `ptr`, `cnt` only.
- First grant possible in the first cycle after `rstn` deasserts.

## Test plan
- All 4 channels logb+loge valid continuously, out_ready=1 -> records ids 0,1,2,3,0,… one per cycle from cycle 1, each out_b=out_e=1, out_data = channel data.
- Only channel 2 logb valid (data 0xA5), loge low -> one record id=2, b=1, e=0, data=0xA5; next cycle ptr=3; loge_ready[2] equals logb_ready[2] every cycle.
- out_ready held 0 with all channels requesting -> exactly 2 grants, then all readies 0; release out_ready -> records drain in grant order, grants resume next cycle, no loss/duplication.
- Channel 3 granted (ptr wraps to 0) with channels 0 and 3 requesting -> next grant channel 0; verify no channel waits more than 4 grants under random stimulus.
- Assert rstn low while cnt=2 and a channel is mid-hold -> out_valid and readies 0 immediately (async); after release ptr=0, FIFO empty, held request granted first-cycle with correct data.
- Random valids/out_ready over 10k cycles, scoreboard per-channel beat order -> every logb/loge beat emitted exactly once, in order, with correct id.
